// File: rtl/if_stage.sv
// Instruction-fetch stage: PC sequencing, instruction-memory request handshake,
// freeze skid buffer and branch redirect/flush into the IF/ID register.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hazard,
    input  logic        sorthazard,
    input  logic        branchTaken,
    input  logic [31:0] branchAddr,
    output logic        imemReq,
    output logic [31:0] imemAddr,
    input  logic        imemAck,
    input  logic [31:0] imemData,
    output logic [31:0] pcOut,
    output logic [31:0] instOut,
    output logic        validOut
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_skid;
    logic [XLEN-1:0] r_target;
    logic [XLEN-1:0] r_pc_out;
    logic [XLEN-1:0] r_inst_out;
    logic            r_valid_out;

    logic [XLEN-1:0] w_pc_next;
    logic [XLEN-1:0] w_skid_next;
    logic [XLEN-1:0] w_target_next;
    logic [XLEN-1:0] w_pc_out_next;
    logic [XLEN-1:0] w_inst_out_next;
    logic            w_valid_out_next;

    logic            w_req;
    logic            w_ack;
    logic            w_freeze;
    logic [XLEN-1:0] w_pc_plus4;

    assign w_freeze   = hazard | sorthazard;
    assign w_ack      = imemAck & w_req;
    assign w_pc_plus4 = r_pc + PC_STEP;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a redirect always wins over a freeze
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH: begin
                if (branchTaken) begin
                    if (!w_ack) w_state_next = DISCARD;
                end else if (w_ack && w_freeze) begin
                    w_state_next = HOLD;
                end
            end
            HOLD: begin
                if (branchTaken || !w_freeze) w_state_next = FETCH;
            end
            DISCARD: begin
                if (w_ack) w_state_next = FETCH;
            end
            default: w_state_next = FETCH;
        endcase
    end

    // Request strobe and datapath next values; everything holds by default
    always_comb begin
        w_req            = (r_state != HOLD);
        w_pc_next        = r_pc;
        w_skid_next      = r_skid;
        w_target_next    = r_target;
        w_pc_out_next    = r_pc_out;
        w_inst_out_next  = r_inst_out;
        w_valid_out_next = r_valid_out;
        case (r_state)
            FETCH: begin
                if (branchTaken) begin
                    w_inst_out_next  = '0;
                    w_valid_out_next = 1'b0;
                    if (w_ack) w_pc_next = branchAddr;
                    else       w_target_next = branchAddr;
                end else if (w_ack) begin
                    if (w_freeze) begin
                        w_skid_next = imemData;
                    end else begin
                        w_pc_out_next    = w_pc_plus4;
                        w_inst_out_next  = imemData;
                        w_valid_out_next = 1'b1;
                        w_pc_next        = w_pc_plus4;
                    end
                end else if (!w_freeze) begin
                    w_inst_out_next  = '0;
                    w_valid_out_next = 1'b0;
                end
            end
            HOLD: begin
                if (branchTaken) begin
                    w_pc_next        = branchAddr;
                    w_inst_out_next  = '0;
                    w_valid_out_next = 1'b0;
                end else if (!w_freeze) begin
                    w_pc_out_next    = w_pc_plus4;
                    w_inst_out_next  = r_skid;
                    w_valid_out_next = 1'b1;
                    w_pc_next        = w_pc_plus4;
                end
            end
            DISCARD: begin
                // The outstanding request belongs to the squashed path
                w_inst_out_next  = '0;
                w_valid_out_next = 1'b0;
                if (w_ack) begin
                    w_pc_next = branchTaken ? branchAddr : r_target;
                end else if (branchTaken) begin
                    w_target_next = branchAddr;
                end
            end
            default: begin
                w_inst_out_next  = '0;
                w_valid_out_next = 1'b0;
            end
        endcase
    end

    // Datapath registers: PC, skid, saved redirect target, IF/ID
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc        <= RESET_PC;
            r_skid      <= '0;
            r_target    <= '0;
            r_pc_out    <= '0;
            r_inst_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_skid      <= w_skid_next;
            r_target    <= w_target_next;
            r_pc_out    <= w_pc_out_next;
            r_inst_out  <= w_inst_out_next;
            r_valid_out <= w_valid_out_next;
        end
    end

    // Request is dropped immediately while reset is held
    assign imemReq  = rst & w_req;
    assign imemAddr = r_pc;
    assign pcOut    = r_pc_out;
    assign instOut  = r_inst_out;
    assign validOut = r_valid_out;

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC loaded on reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-004 SHALL have port hazard  input  1  data-hazard freeze request from the hazard unit.
REQ-005 SHALL have port sorthazard  input  1  sort-instruction freeze request from the hazard unit.
REQ-006 SHALL have port branchTaken  input  1  redirect/flush request from the execute stage.
REQ-007 SHALL have port branchAddr  input  32  redirect target, sampled when branchTaken=1.
REQ-008 SHALL have port imemReq  output  1  instruction-memory request.
REQ-009 SHALL have port imemAddr  output  32  request address; word aligned.
REQ-010 SHALL have port imemAck  input  1  one-cycle data-valid response; latency 1..N cycles.
REQ-011 SHALL have port imemData  input  32  instruction word, valid when imemAck=1.
REQ-012 SHALL have ports pcOut/instOut/validOut  output  32/32/1  IF/ID register: PC+4, instruction, valid.

Function
REQ-013 SHALL define freeze = hazard | sorthazard.
REQ-014 SHALL implement states FETCH, HOLD, DISCARD; imemReq=1 in FETCH and DISCARD, 0 in HOLD.
REQ-015 SHALL keep imemAddr and imemReq stable from assertion until the cycle imemAck=1 (no mid-request address change).
REQ-016 SHALL drive imemAddr = pc in FETCH and DISCARD.
REQ-017 FETCH, imemAck=1, branchTaken=0, freeze=0: IF/ID <= {pc+4, imemData, 1}; pc <= pc+4; stay FETCH; new request next cycle (min 1 instr/cycle when ack is same-cycle).
REQ-018 FETCH, imemAck=1, branchTaken=0, freeze=1: imemData into skid register; IF/ID unchanged; -> HOLD.
REQ-019 FETCH, imemAck=0, branchTaken=0: IF/ID unchanged if freeze=1, else validOut<=0, instOut<=0 (bubble); pc unchanged.
REQ-020 FETCH, branchTaken=1, imemAck=1: response dropped; pc <= branchAddr; IF/ID flushed (validOut=0, instOut=0); stay FETCH.
REQ-021 FETCH, branchTaken=1, imemAck=0: target saved; IF/ID flushed; -> DISCARD.
REQ-022 DISCARD: request to old pc held; validOut=0; new branchTaken overwrites saved target (latest wins); on imemAck: data dropped, pc <= saved target (or branchAddr if branchTaken that cycle), -> FETCH.
REQ-023 HOLD: freeze=1 holds everything; freeze=0: IF/ID <= {pc+4, skid, 1}, pc <= pc+4, -> FETCH.
REQ-024 HOLD, branchTaken=1: skid dropped; pc <= branchAddr; IF/ID flushed; -> FETCH.
REQ-025 branchTaken SHALL take priority over freeze in every state.
REQ-026 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.

Reset
REQ-027 With rst=0 at a rising edge: pc=RESET_PC, state=FETCH, pcOut=0, instOut=0, validOut=0, skid=0, saved target=0.
REQ-028 imemReq SHALL be 0 while rst=0; reset mid-request abandons it and any late imemAck is ignored until imemReq reasserts.

Verification
REQ-029 Reset, then imemAck same cycle with data 0xE3A0_0001, no freeze -> cycle 1: pcOut=4, instOut=0xE3A00001, validOut=1; imemAddr=4.
REQ-030 3-cycle memory latency, no hazards -> imemAddr 0 held 3 cycles; bubbles (validOut=0) between instructions; pcOut 4, 8, 12.
REQ-031 hazard=1 for 3 cycles when ack arrives for addr 8 -> IF/ID frozen at previous value, imemReq=0 in HOLD; on release pcOut=12 with skid word, next imemAddr=12.
REQ-032 branchTaken=1, branchAddr=0x100 while request to 0x10 outstanding -> imemAddr stays 0x10 until ack, data dropped, validOut=0, next imemAddr=0x100.
REQ-033 branchTaken=1 and sorthazard=1 same cycle in HOLD -> flush, next imemAddr=branchAddr, no skid word ever output.
REQ-034 rst=0 asserted in DISCARD -> next cycle pc=RESET_PC, validOut=0, imemReq=0; saved target never used.
